nonce_dispatcher: RTL and testbench

Work-issuing controller that drives one HashEngine core.
- Accepts a mining job: second-chunk header tail plus a nonce range.
- Generates the round counter, Kt and Wt for the first SHA-256 pass, including the message schedule.
- Consumes the engine's completion/found pulses and sweeps nonces until the engine finds a block or the range is exhausted.
- Reports the result to the host over a valid/ready handshake.

---
 rtl/sha_dispatch_pkg.sv | 39 +++
 rtl/nonce_dispatcher_if.sv | 28 ++
 rtl/msg_sched.sv | 42 ++++
 rtl/nonce_dispatcher.sv | 172 +++++++++++++++++
 tb/tb_nonce_dispatcher.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_dispatch_pkg.sv
// ---- sha_dispatch_pkg (rev 1.0) ----
// Shared types, SHA-256 round constants and schedule helpers for the nonce dispatcher.
`default_nettype none

package sha_dispatch_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_PASS1  = 3'd2,
        S_PASS2  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    localparam logic [31:0] PAD_W4  = 32'h8000_0000;
    localparam logic [31:0] PAD_W15 = 32'h0000_0280;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nonce_dispatcher_if.sv
// ---- nonce_dispatcher_if (rev 1.0) ----
// Host-side job and result handshakes of the nonce dispatcher.
`default_nettype none

interface nonce_dispatcher_if;
    logic        job_valid;
    logic        job_ready;
    logic [95:0] job_tail;
    logic [31:0] job_nonce_start;
    logic [31:0] job_nonce_end;
    logic        res_valid;
    logic        res_ready;
    logic        res_found;
    logic [31:0] res_nonce;
    logic [3:0]  res_core;

    modport master (
        output job_valid, job_tail, job_nonce_start, job_nonce_end, res_ready,
        input  job_ready, res_valid, res_found, res_nonce, res_core
    );

    modport slave (
        input  job_valid, job_tail, job_nonce_start, job_nonce_end, res_ready,
        output job_ready, res_valid, res_found, res_nonce, res_core
    );
endinterface

`default_nettype wire

// File: rtl/msg_sched.sv
// ---- msg_sched (rev 1.0) ----
// SHA-256 message schedule as a 16-word sliding window; wt is always window word 0.
`default_nettype none

module msg_sched
    import sha_dispatch_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         load,
    input  wire logic         advance,
    input  wire logic [511:0] load_blk,
    output logic      [31:0]  wt
);

    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    always_comb begin
        for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
        if (load) begin
            for (int i = 0; i < 16; i++) win_d[i] = load_blk[511 - 32*i -: 32];
        end else if (advance) begin
            for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
            // Window holds W[t..t+15]; the new tail word is W[t+16]
            win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
        end
    end

    assign wt = win_q[0];

endmodule

`default_nettype wire

// File: rtl/nonce_dispatcher.sv
// ---- nonce_dispatcher (rev 1.0) ----
// Sweeps a nonce range through one HashEngine; DISPATCH_STAT_EN adds hash_cnt/timeout_cnt.
`default_nettype none

module nonce_dispatcher #(
    parameter int         TIMEOUT_CYC = 256,
    parameter logic [3:0] CORE_ID     = 4'h0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    nonce_dispatcher_if.slave host,
    output logic             eng_rst,
    output logic             eng_en,
    output logic [5:0]       eng_rcntr,
    output logic [31:0]      eng_kt,
    output logic [31:0]      eng_wt,
    input  wire logic        eng_inc_non,
    input  wire logic        eng_cmpltn,
    input  wire logic        eng_blk_fnd,
`ifdef DISPATCH_STAT_EN
    output logic [31:0]      hash_cnt,
    output logic [15:0]      timeout_cnt,
`endif
    output logic             busy
);
    import sha_dispatch_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state_q, state_d;
    logic [95:0]   tail_q, tail_d;
    logic [31:0]   nonce_q, nonce_d, end_q, end_d, kt_q, kt_d, sched_wt;
    logic          found_q, found_d, sched_load, sched_adv, next_in_pass;
    logic [5:0]    rcntr_q, rcntr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          job_acc, in_pass, timeout, pass_done;

    assign job_acc   = host.job_valid && (state_q == S_IDLE);
    assign in_pass   = (state_q == S_PASS1) || (state_q == S_PASS2);
    assign timeout   = in_pass && (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign pass_done = in_pass && (eng_cmpltn || timeout);

    always_comb begin
        state_d    = state_q;
        tail_d     = tail_q;
        nonce_d    = nonce_q;
        end_d      = end_q;
        found_d    = found_q;
        rcntr_d    = rcntr_q;
        tmo_d      = tmo_q;
        sched_load = 1'b0;
        sched_adv  = 1'b0;
        case (state_q)
            S_IDLE: if (job_acc) begin
                tail_d  = host.job_tail;
                nonce_d = host.job_nonce_start;
                end_d   = host.job_nonce_end;
                found_d = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                sched_load = 1'b1;
                tmo_d      = '0;
                rcntr_d    = '0;
                state_d    = S_PASS1;
            end
            S_PASS1: begin
                sched_adv = 1'b1;
                rcntr_d   = rcntr_q + 6'd1;
                tmo_d     = tmo_q + TW'(1);
                if (rcntr_q == 6'd63) state_d = S_PASS2;
            end
            S_PASS2: begin
                rcntr_d = rcntr_q + 6'd1;
                tmo_d   = tmo_q + TW'(1);
            end
            S_RESULT: if (host.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A real completion takes priority over a timeout in the same cycle
        if (pass_done) begin
            if (eng_cmpltn && eng_blk_fnd) begin
                found_d = 1'b1;
                state_d = S_RESULT;
            end else if (nonce_q == end_q) begin
                found_d = 1'b0;
                state_d = S_RESULT;
            end else begin
                nonce_d = nonce_q + 32'd1;
                state_d = S_START;
            end
        end
        next_in_pass = (state_d == S_PASS1) || (state_d == S_PASS2);
        if (!next_in_pass) rcntr_d = '0;
        kt_d = next_in_pass ? K[rcntr_d] : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tail_q  <= '0;
            nonce_q <= '0;
            end_q   <= '0;
            found_q <= 1'b0;
            rcntr_q <= '0;
            kt_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            nonce_q <= nonce_d;
            end_q   <= end_d;
            found_q <= found_d;
            rcntr_q <= rcntr_d;
            kt_q    <= kt_d;
            tmo_q   <= tmo_d;
        end
    end

    msg_sched u_sched (
        .clk      (clk),
        .rst      (rst),
        .load     (sched_load),
        .advance  (sched_adv),
        .load_blk ({tail_q, nonce_q, PAD_W4, 320'd0, PAD_W15}),
        .wt       (sched_wt)
    );

    assign host.job_ready = (state_q == S_IDLE);
    assign host.res_valid = (state_q == S_RESULT);
    assign host.res_found = (state_q == S_RESULT) && found_q;
    assign host.res_nonce = (state_q == S_RESULT) ? nonce_q : 32'd0;
    assign host.res_core  = (state_q == S_RESULT) ? CORE_ID : 4'd0;
    assign eng_rst        = (state_q == S_START);
    assign eng_en         = in_pass;
    assign eng_rcntr      = rcntr_q;
    assign eng_kt         = kt_q;
    assign eng_wt         = (state_q == S_PASS1) ? sched_wt : 32'd0;
    assign busy           = (state_q != S_IDLE);

`ifdef DISPATCH_STAT_EN
    logic [31:0] hash_cnt_q, hash_cnt_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;

    always_comb begin
        hash_cnt_d    = hash_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        if (job_acc) hash_cnt_d = '0;
        else if (eng_inc_non && (hash_cnt_q != '1)) hash_cnt_d = hash_cnt_q + 32'd1;
        if (timeout && !eng_cmpltn && (timeout_cnt_q != '1)) timeout_cnt_d = timeout_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            hash_cnt_q    <= hash_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign hash_cnt    = hash_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
`else
    logic unused_inc_non;
    assign unused_inc_non = eng_inc_non;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nonce_dispatcher.sv
// ---- tb_nonce_dispatcher (rev 1.0) ----
// Directed jobs against an engine model plus a per-cycle reference of rounds, K and W.
`default_nettype none
`timescale 1ns/1ps

module tb_nonce_dispatcher;
    localparam int TMO = 256;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eng_rst, eng_en, busy;
    logic [5:0]  eng_rcntr;
    logic [31:0] eng_kt, eng_wt;
    logic        eng_inc_non = 1'b0, eng_cmpltn = 1'b0, eng_blk_fnd = 1'b0;
`ifdef DISPATCH_STAT_EN
    logic [31:0] hash_cnt;
    logic [15:0] timeout_cnt;
`endif

    nonce_dispatcher_if ifc ();

    nonce_dispatcher #(.TIMEOUT_CYC(TMO), .CORE_ID(4'hA)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (ifc),
        .eng_rst     (eng_rst),
        .eng_en      (eng_en),
        .eng_rcntr   (eng_rcntr),
        .eng_kt      (eng_kt),
        .eng_wt      (eng_wt),
        .eng_inc_non (eng_inc_non),
        .eng_cmpltn  (eng_cmpltn),
        .eng_blk_fnd (eng_blk_fnd),
`ifdef DISPATCH_STAT_EN
        .hash_cnt    (hash_cnt),
        .timeout_cnt (timeout_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bs0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] bs1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    // Engine configuration, written by the test sequence only
    int          cfg_delay = 0;
    bit          cfg_fen   = 1'b0;
    logic [31:0] cfg_fn    = '0;

    // Reference state, written by the monitor only
    logic [95:0] tail_m;
    logic [31:0] end_m, cur;
    logic [31:0] wref [64];
    logic [31:0] nlog [8];
    logic [31:0] cap16, cap17, capk0, capk63;
    int          n_rst = 0;

    initial begin : monitor
        bit active;
        int cnt, r64, expect_next;
        bit exp_found;
        active = 1'b0;
        expect_next = 0;
        forever begin
            @(negedge clk);
            eng_cmpltn  = 1'b0;
            eng_blk_fnd = 1'b0;
            eng_inc_non = 1'b0;
            if (rst) begin
                active = 1'b0;
                expect_next = 0;
            end else begin
                if (ifc.job_valid && ifc.job_ready) begin
                    tail_m = ifc.job_tail;
                    end_m  = ifc.job_nonce_end;
                    cur    = ifc.job_nonce_start - 32'd1;
                    n_rst  = 0;
                end
                if (expect_next == 1) chk("handoff_rst", 32'(eng_rst), 32'd1);
                if (expect_next == 2) begin
                    chk("res_valid", 32'(ifc.res_valid), 32'd1);
                    chk("res_found", 32'(ifc.res_found), 32'(exp_found));
                    chk("res_nonce", ifc.res_nonce, cur);
                    chk("res_core", 32'(ifc.res_core), 32'hA);
                end
                expect_next = 0;
                if (eng_rst) begin
                    cur = cur + 32'd1;
                    if (n_rst < 8) nlog[n_rst] = cur;
                    n_rst++;
                    wref[0] = tail_m[95:64];
                    wref[1] = tail_m[63:32];
                    wref[2] = tail_m[31:0];
                    wref[3] = cur;
                    wref[4] = 32'h8000_0000;
                    for (int t = 5; t < 15; t++) wref[t] = 32'd0;
                    wref[15] = 32'h0000_0280;
                    for (int t = 16; t < 64; t++)
                        wref[t] = bs1(wref[t-2]) + wref[t-7] + bs0(wref[t-15]) + wref[t-16];
                    chk("start_en", 32'(eng_en), 32'd0);
                    chk("start_rcntr", 32'(eng_rcntr), 32'd0);
                    active = 1'b1;
                    cnt = 0;
                end else if (active) begin
                    cnt++;
                    r64 = (cnt - 1) % 64;
                    chk("en", 32'(eng_en), 32'd1);
                    chk("rcntr", 32'(eng_rcntr), 32'(r64));
                    chk("kt", eng_kt, KT[r64]);
                    chk("wt", eng_wt, (cnt <= 64) ? wref[cnt-1] : 32'd0);
                    if (n_rst == 1) begin
                        if (cnt == 1)  capk0  = eng_kt;
                        if (cnt == 17) cap16  = eng_wt;
                        if (cnt == 18) cap17  = eng_wt;
                        if (cnt == 64) capk63 = eng_kt;
                    end
                    if (cnt == 64) eng_inc_non = 1'b1;
                    if (cfg_delay != 0 && cnt == cfg_delay) begin
                        eng_cmpltn  = 1'b1;
                        eng_blk_fnd = cfg_fen && (cur == cfg_fn);
                    end
                    if (eng_cmpltn || cnt == TMO) begin
                        active = 1'b0;
                        if (eng_blk_fnd) begin
                            expect_next = 2; exp_found = 1'b1;
                        end else if (cur == end_m) begin
                            expect_next = 2; exp_found = 1'b0;
                        end else begin
                            expect_next = 1;
                        end
                    end
                end else begin
                    chk("idle_en", 32'(eng_en), 32'd0);
                end
            end
        end
    end

    task automatic start_job(input logic [95:0] tail, input logic [31:0] s, input logic [31:0] e,
                             input int delay, input bit fen, input logic [31:0] fn);
        @(posedge clk);
        #1;
        cfg_delay = delay;
        cfg_fen   = fen;
        cfg_fn    = fn;
        ifc.job_tail        = tail;
        ifc.job_nonce_start = s;
        ifc.job_nonce_end   = e;
        ifc.job_valid       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_while_busy", 32'(ifc.job_ready), 32'd0);
        ifc.job_valid = 1'b0;
    endtask

    task automatic finish_job(input bit ef, input logic [31:0] en, input int ep, input int ecyc);
        int  cyc;
        bit  got;
        logic [31:0] held;
        cyc = 2;
        got = 1'b0;
        while (cyc < 3000 && !got) begin
            @(negedge clk);
            cyc++;
            if (ifc.res_valid) got = 1'b1;
        end
        chk("result_seen", 32'(got), 32'd1);
        chk("job_found", 32'(ifc.res_found), 32'(ef));
        chk("job_nonce", ifc.res_nonce, en);
        chk("eng_rst_pulses", 32'(n_rst), 32'(ep));
        if (ecyc != 0) chk("job_cycles", 32'(cyc), 32'(ecyc));
        held = ifc.res_nonce;
        repeat (3) begin
            @(negedge clk);
            chk("res_hold_valid", 32'(ifc.res_valid), 32'd1);
            chk("res_hold_nonce", ifc.res_nonce, held);
        end
        ifc.res_ready = 1'b1;
        @(negedge clk);
        chk("res_drop", 32'(ifc.res_valid), 32'd0);
        chk("ready_after_res", 32'(ifc.job_ready), 32'd1);
        ifc.res_ready = 1'b0;
    endtask

    initial begin : test
        bit seen;
        ifc.job_valid = 1'b0;
        ifc.job_tail = '0;
        ifc.job_nonce_start = '0;
        ifc.job_nonce_end = '0;
        ifc.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_job_ready", 32'(ifc.job_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(ifc.res_valid), 32'd0);
        chk("rst_res_nonce", ifc.res_nonce, 32'd0);
        chk("rst_res_core", 32'(ifc.res_core), 32'd0);
        chk("rst_eng_rcntr", 32'(eng_rcntr), 32'd0);
        chk("rst_eng_kt", eng_kt, 32'd0);
        chk("rst_eng_misc", {28'd0, eng_rst, eng_en, ifc.res_found, |eng_wt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single nonce, engine reports a miss at cycle 100
        start_job(96'd0, 32'd5, 32'd5, 100, 1'b0, 32'd0);
        finish_job(1'b0, 32'd5, 1, 0);

        // Found on the fourth nonce
        start_job(96'h0123_4567_89ab_cdef_dead_beef, 32'd10, 32'd20, 70, 1'b1, 32'd13);
        finish_job(1'b1, 32'd13, 4, 0);

        // Schedule reference pinned by hand-computed words
        start_job({32'h1111_1111, 32'h2222_2222, 32'h3333_3333}, 32'd0, 32'd0, 70, 1'b0, 32'd0);
        finish_job(1'b0, 32'd0, 1, 0);
        chk("kt_round0", capk0, 32'h428A_2F98);
        chk("kt_round63", capk63, 32'hC671_78F2);
        chk("wt_round16", cap16, 32'hD999_9999);
        chk("wt_round17", cap17, 32'hCFFE_EEEE);

        // Engine silent: both nonces time out after 256 PASS cycles each
        start_job(96'h5, 32'd7, 32'd8, 0, 1'b0, 32'd0);
        finish_job(1'b0, 32'd8, 2, 516);

        // Range through the 32-bit wrap
        start_job(96'h9, 32'hFFFF_FFFE, 32'h0000_0001, 20, 1'b0, 32'd0);
        finish_job(1'b0, 32'd1, 4, 0);
        chk("wrap_n0", nlog[0], 32'hFFFF_FFFE);
        chk("wrap_n1", nlog[1], 32'hFFFF_FFFF);
        chk("wrap_n2", nlog[2], 32'h0000_0000);
        chk("wrap_n3", nlog[3], 32'h0000_0001);

        // Asynchronous reset in PASS1 round 30, then a fresh job
        start_job(96'h3, 32'd3, 32'd3, 0, 1'b0, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (eng_en && eng_rcntr == 6'd30) seen = 1'b1;
        end
        chk("reach_round30", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_job_ready", 32'(ifc.job_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_eng", {25'd0, eng_rst, eng_en, ifc.res_valid, ifc.res_found, |eng_wt, |eng_kt, |eng_rcntr}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_job(96'h77, 32'd9, 32'd9, 30, 1'b1, 32'd9);
        finish_job(1'b1, 32'd9, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
